pc_predictor: RTL and testbench
===============================

# pc_predictor

Parametrised fetch-stage program counter with a direct-mapped branch target buffer (BTB) of 2-bit saturating predictors. It replaces the fixed, non-predicting PC unit in the pipelined CPU. Each cycle it produces the fetch address and a predicted next PC. It takes branch and jump resolution from EX, redirects fetch on a misprediction, and keeps jump and misprediction statistics for the board display.

## Interface
- ADDR_WIDTH, 32: PC / target width; bits [1:0] of every PC are always 0.
- BHT_DEPTH, 16: BTB entries; power of 2, at least 2. IDX = log2(BHT_DEPTH).
- STAT_WIDTH, 25: width of each statistics counter.
- RESET_PC, 0: PC value loaded on reset.
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; wins over every other input.
- enable  in  1  fetch advance enable; 0 holds pc (stall).
- bubble  in  1  EX stage holds a bubble; 1 masks all resolve inputs.
- resolveValid  in  1  EX carries a resolved control-flow instruction.
- resolveIsBranch  in  1  conditional branch (beq/bne/bltz).
- resolveIsJump  in  1  unconditional (j/jal/jr).
- resolveTaken  in  1  actual outcome; forced 1 internally when resolveIsJump.
- resolvePc  in  ADDR_WIDTH  address of the resolving instruction.
- resolveTarget  in  ADDR_WIDTH  actual taken target.
- resolvePredNext  in  ADDR_WIDTH  nextPc that was predicted when this instruction was fetched, piped down.
- pc  out  ADDR_WIDTH  current fetch address (registered).
- nextPc  out  ADDR_WIDTH  predicted next fetch address (combinational).
- predictTaken  out  1  BTB hit with counter >= 2 (combinational).
- flush  out  1  misprediction detected this cycle (combinational).
- totalCycle, unconditionalJump, conditionalJump, conditionalSuccessfulJump, mispredictCount  out  STAT_WIDTH  each.

## Operation
- Index is pc[IDX+1:2]. Tag is pc[ADDR_WIDTH-1:IDX+2].
- Each BTB entry holds {valid, tag, target, ctr[1:0]}. The array is read asynchronously and written on the clock edge.
- Lookup: hit = valid && tag match. predictTaken = hit && ctr[1]. nextPc = predictTaken ? target : pc+4.
- A resolve is active when resolveValid && !bubble && (resolveIsBranch || resolveIsJump). If both IsBranch and IsJump are set, the instruction is treated as a jump.
- actualNext = taken ? resolveTarget : resolvePc+4.
- flush = active && (actualNext != resolvePredNext).
- BTB update on an active resolve, at entry index(resolvePc):
  - Jump: write valid=1, tag, target, ctr=3.
  - Taken branch, hit: ctr = min(ctr+1, 3); target rewritten.
  - Taken branch, miss: allocate with ctr=2, replacing any aliasing entry.
  - Not-taken branch, hit: ctr = max(ctr-1, 0); target unchanged.
  - Not-taken branch, miss: no write.
- PC update priority:
  1. reset: pc = RESET_PC.
  2. flush: pc = actualNext, regardless of enable.
  3. !enable: hold.
  4. Otherwise: pc = nextPc.
- Statistics. All counters wrap modulo 2^STAT_WIDTH; none saturate.
  - totalCycle: +1 every non-reset cycle, including stalls.
  - unconditionalJump: +1 per active jump.
  - conditionalJump: +1 per active branch.
  - conditionalSuccessfulJump: +1 per active taken branch.
  - mispredictCount: +1 per flush.
- Reset clears every valid bit and every ctr to 0, sets pc = RESET_PC, and zeroes all statistics.

## Timing
- pc is registered. nextPc, predictTaken and flush are combinational and valid in the same cycle as their inputs.
- Redirect latency: flush in cycle N gives pc = actualNext in cycle N+1.
- Read during write: a lookup and an update to the same index in the same cycle see the old entry. The new entry is visible from the next cycle.
- Reset during an active resolve: no BTB write and no statistics increment; reset values appear the following cycle.
- When pc+4 overflows ADDR_WIDTH it wraps to 0, with no special handling.
- Reset values: pc=RESET_PC, predictTaken=0, nextPc=RESET_PC+4, all statistics 0. flush follows its inputs, so it is 0 whenever no resolve is active.

## Test plan
- **Reset and stall:** reset for 1 edge, then enable=1 for 3 cycles, then enable=0 for 2 cycles.
  - pc sequence 0, 4, 8, 12, 12, 12.
  - totalCycle=5, all other counters 0.
- **First taken branch:** resolvePc=0x10, taken, target 0x40, predNext=0x14.
  - flush=1 and next pc=0x40.
  - conditionalJump=1, conditionalSuccessfulJump=1, mispredictCount=1.
  - Later at pc=0x10: predictTaken=1, nextPc=0x40.
- **Alias:** pc=0x50 (index 4, different tag from 0x10).
  - predictTaken=0, nextPc=0x54.
  - A taken resolve at 0x50 then evicts the 0x10 entry.
- **Hysteresis:** after 0x10 reaches ctr=3, one not-taken resolve leaves predictTaken=1. A second gives predictTaken=0. Each not-taken resolve whose predNext was 0x40 flushes to 0x14.
- **Masking and jump:** a jr resolve with bubble=1 changes neither the BTB nor any counter. The same resolve with bubble=0, target 0x100, correct predNext=0x100 gives unconditionalJump+1 and flush=0.
- **Priority:** flush with enable=0 still redirects pc. Reset asserted together with an active resolve leaves the BTB empty and all counters 0.

Source files
------------

// File: rtl/pc_predictor.sv
// Fetch PC with a direct-mapped BTB of 2-bit saturating counters; redirects on EX mispredict.
// pc is registered; nextPc/predictTaken/flush are combinational. Stall holds pc, flush overrides stall.
module pc_predictor #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    BHT_DEPTH  = 16,
  parameter int                    STAT_WIDTH = 25,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  bubble,
  input  logic                  resolveValid,
  input  logic                  resolveIsBranch,
  input  logic                  resolveIsJump,
  input  logic                  resolveTaken,
  input  logic [ADDR_WIDTH-1:0] resolvePc,
  input  logic [ADDR_WIDTH-1:0] resolveTarget,
  input  logic [ADDR_WIDTH-1:0] resolvePredNext,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] nextPc,
  output logic                  predictTaken,
  output logic                  flush,
  output logic [STAT_WIDTH-1:0] totalCycle,
  output logic [STAT_WIDTH-1:0] unconditionalJump,
  output logic [STAT_WIDTH-1:0] conditionalJump,
  output logic [STAT_WIDTH-1:0] conditionalSuccessfulJump,
  output logic [STAT_WIDTH-1:0] mispredictCount
);
  localparam int IDX  = $clog2(BHT_DEPTH);
  localparam int TAGW = ADDR_WIDTH - IDX - 2;

  logic                  valid_q  [BHT_DEPTH];
  logic [TAGW-1:0]       tag_q    [BHT_DEPTH];
  logic [ADDR_WIDTH-1:0] target_q [BHT_DEPTH];
  logic [1:0]            ctr_q    [BHT_DEPTH];

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [STAT_WIDTH-1:0] total_q, ujump_q, cjump_q, csucc_q, mispred_q;

  // Fetch-side lookup
  logic [IDX-1:0]  lk_idx;
  logic [TAGW-1:0] lk_tag;
  logic            lk_hit;

  assign lk_idx       = pc_q[IDX+1:2];
  assign lk_tag       = pc_q[ADDR_WIDTH-1:IDX+2];
  assign lk_hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign predictTaken = lk_hit && ctr_q[lk_idx][1];
  assign nextPc       = predictTaken ? target_q[lk_idx] : pc_q + ADDR_WIDTH'(4);

  // EX-side resolve; a jump flag dominates a simultaneous branch flag
  logic                  is_jump, is_branch, active, taken;
  logic [ADDR_WIDTH-1:0] actual_next;
  logic [IDX-1:0]        rs_idx;
  logic [TAGW-1:0]       rs_tag;
  logic                  rs_hit;
  logic [1:0]            rs_ctr;

  assign is_jump     = resolveIsJump;
  assign is_branch   = resolveIsBranch && !resolveIsJump;
  assign active      = resolveValid && !bubble && (is_branch || is_jump);
  assign taken       = resolveTaken || is_jump;
  assign actual_next = taken ? resolveTarget : resolvePc + ADDR_WIDTH'(4);
  assign flush       = active && (actual_next != resolvePredNext);

  assign rs_idx = resolvePc[IDX+1:2];
  assign rs_tag = resolvePc[ADDR_WIDTH-1:IDX+2];
  assign rs_hit = valid_q[rs_idx] && (tag_q[rs_idx] == rs_tag);
  assign rs_ctr = ctr_q[rs_idx];

  logic       entry_we, ctr_we;
  logic [1:0] ctr_d;

  always_comb begin
    entry_we = active && taken;
    ctr_we   = active && (taken || rs_hit);
    ctr_d    = rs_ctr;
    if (is_jump)
      ctr_d = 2'd3;
    else if (taken && rs_hit)
      ctr_d = (rs_ctr == 2'd3) ? 2'd3 : rs_ctr + 2'd1;
    else if (taken)
      ctr_d = 2'd2;
    else if (rs_hit)
      ctr_d = (rs_ctr == 2'd0) ? 2'd0 : rs_ctr - 2'd1;
  end

  always_comb begin
    pc_d = pc_q;
    if (flush)
      pc_d = actual_next;
    else if (enable)
      pc_d = nextPc;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'd0;
      end
    end else begin
      if (entry_we) valid_q[rs_idx] <= 1'b1;
      if (ctr_we)   ctr_q[rs_idx]   <= ctr_d;
    end
  end

  // Tag/target need no reset: they are qualified by valid
  always_ff @(posedge clock) begin
    if (!reset && entry_we) begin
      tag_q[rs_idx]    <= rs_tag;
      target_q[rs_idx] <= resolveTarget;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      total_q   <= '0;
      ujump_q   <= '0;
      cjump_q   <= '0;
      csucc_q   <= '0;
      mispred_q <= '0;
    end else begin
      pc_q    <= pc_d;
      total_q <= total_q + STAT_WIDTH'(1);
      if (active && is_jump)            ujump_q   <= ujump_q + STAT_WIDTH'(1);
      if (active && is_branch)          cjump_q   <= cjump_q + STAT_WIDTH'(1);
      if (active && is_branch && taken) csucc_q   <= csucc_q + STAT_WIDTH'(1);
      if (flush)                        mispred_q <= mispred_q + STAT_WIDTH'(1);
    end
  end

  assign pc                        = pc_q;
  assign totalCycle                = total_q;
  assign unconditionalJump         = ujump_q;
  assign conditionalJump           = cjump_q;
  assign conditionalSuccessfulJump = csucc_q;
  assign mispredictCount           = mispred_q;
endmodule

// File: tb/tb_pc_predictor.sv
// Directed bench for pc_predictor: hand-computed PC sequences, BTB behaviour and statistics.
module tb_pc_predictor;
  logic        clock, reset, enable, bubble;
  logic        resolveValid, resolveIsBranch, resolveIsJump, resolveTaken;
  logic [31:0] resolvePc, resolveTarget, resolvePredNext;
  logic [31:0] pc, nextPc;
  logic        predictTaken, flush;
  logic [24:0] totalCycle, unconditionalJump, conditionalJump;
  logic [24:0] conditionalSuccessfulJump, mispredictCount;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_tc, exp_uj, exp_cj, exp_sj, exp_mp;

  pc_predictor dut (
    .clock(clock), .reset(reset), .enable(enable), .bubble(bubble),
    .resolveValid(resolveValid), .resolveIsBranch(resolveIsBranch),
    .resolveIsJump(resolveIsJump), .resolveTaken(resolveTaken),
    .resolvePc(resolvePc), .resolveTarget(resolveTarget),
    .resolvePredNext(resolvePredNext),
    .pc(pc), .nextPc(nextPc), .predictTaken(predictTaken), .flush(flush),
    .totalCycle(totalCycle), .unconditionalJump(unconditionalJump),
    .conditionalJump(conditionalJump),
    .conditionalSuccessfulJump(conditionalSuccessfulJump),
    .mispredictCount(mispredictCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic r;
    r = reset;
    @(posedge clock);
    #1;
    if (r) begin
      exp_tc = 0; exp_uj = 0; exp_cj = 0; exp_sj = 0; exp_mp = 0;
    end else begin
      exp_tc++;
    end
  endtask

  task automatic check_stats(input string tag);
    check_eq({tag, ".totalCycle"}, 64'(totalCycle), 64'(exp_tc));
    check_eq({tag, ".uncondJump"}, 64'(unconditionalJump), 64'(exp_uj));
    check_eq({tag, ".condJump"}, 64'(conditionalJump), 64'(exp_cj));
    check_eq({tag, ".condTaken"}, 64'(conditionalSuccessfulJump), 64'(exp_sj));
    check_eq({tag, ".mispredict"}, 64'(mispredictCount), 64'(exp_mp));
  endtask

  // Present one resolve for a single edge, checking the hand-computed flush first
  task automatic resolve(input logic br, input logic jp, input logic tk, input logic bub,
                         input logic [31:0] rpc, input logic [31:0] tgt,
                         input logic [31:0] pred, input logic exp_fl, input string tag);
    resolveValid = 1'b1; resolveIsBranch = br; resolveIsJump = jp;
    resolveTaken = tk; bubble = bub;
    resolvePc = rpc; resolveTarget = tgt; resolvePredNext = pred;
    #1;
    check_eq({tag, ".flush"}, 64'(flush), 64'(exp_fl));
    if (!bub) begin
      if (jp) exp_uj++;
      else begin
        exp_cj++;
        if (tk) exp_sj++;
      end
      if (exp_fl) exp_mp++;
    end
    step();
    resolveValid = 1'b0; resolveIsBranch = 1'b0; resolveIsJump = 1'b0;
    resolveTaken = 1'b0; bubble = 1'b0;
    resolvePc = '0; resolveTarget = '0; resolvePredNext = '0;
    #1;
  endtask

  // Steer pc to dst with a mispredicted not-taken branch at dst-4 (a BTB miss: no write)
  task automatic redirect(input logic [31:0] dst, input string tag);
    resolve(1'b1, 1'b0, 1'b0, 1'b0, dst - 32'd4, 32'h40, 32'h40, 1'b1, tag);
    check_eq({tag, ".pc"}, 64'(pc), 64'(dst));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; bubble = 1'b0;
    resolveValid = 1'b0; resolveIsBranch = 1'b0; resolveIsJump = 1'b0; resolveTaken = 1'b0;
    resolvePc = '0; resolveTarget = '0; resolvePredNext = '0;
    exp_tc = 0; exp_uj = 0; exp_cj = 0; exp_sj = 0; exp_mp = 0;

    // Reset and stall
    step();
    check_eq("rst.pc", 64'(pc), 64'h0);
    check_eq("rst.nextPc", 64'(nextPc), 64'h4);
    check_eq("rst.predictTaken", 64'(predictTaken), 64'h0);
    check_eq("rst.flush", 64'(flush), 64'h0);
    check_stats("rst");
    reset = 1'b0; enable = 1'b1;
    step(); check_eq("run.pc1", 64'(pc), 64'h4);
    step(); check_eq("run.pc2", 64'(pc), 64'h8);
    step(); check_eq("run.pc3", 64'(pc), 64'hC);
    enable = 1'b0;
    step(); check_eq("stall.pc1", 64'(pc), 64'hC);
    step(); check_eq("stall.pc2", 64'(pc), 64'hC);
    check_eq("stall.totalCycle", 64'(totalCycle), 64'd5);
    check_stats("stall");

    // First taken branch (also flush overriding enable=0)
    resolve(1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h40, 32'h14, 1'b1, "br1");
    check_eq("br1.pc", 64'(pc), 64'h40);
    check_eq("br1.mispredict", 64'(mispredictCount), 64'd1);
    check_stats("br1");
    redirect(32'h10, "to10a");
    check_eq("hit10.predictTaken", 64'(predictTaken), 64'h1);
    check_eq("hit10.nextPc", 64'(nextPc), 64'h40);

    // Alias at index 4
    redirect(32'h50, "to50");
    check_eq("alias.predictTaken", 64'(predictTaken), 64'h0);
    check_eq("alias.nextPc", 64'(nextPc), 64'h54);
    resolve(1'b1, 1'b0, 1'b1, 1'b0, 32'h50, 32'h80, 32'h54, 1'b1, "alias.br");
    check_eq("alias.pc", 64'(pc), 64'h80);
    redirect(32'h10, "to10b");
    check_eq("evict.predictTaken", 64'(predictTaken), 64'h0);
    check_eq("evict.nextPc", 64'(nextPc), 64'h14);

    // Hysteresis: reallocate 0x10 (ctr 2), strengthen to 3, then two not-taken
    resolve(1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h40, 32'h14, 1'b1, "hy.alloc");
    check_eq("hy.alloc.pc", 64'(pc), 64'h40);
    resolve(1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h40, 32'h40, 1'b0, "hy.inc");
    check_eq("hy.inc.pc", 64'(pc), 64'h40);
    redirect(32'h10, "to10c");
    check_eq("hy.c3.predictTaken", 64'(predictTaken), 64'h1);
    resolve(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h40, 32'h40, 1'b1, "hy.nt1");
    check_eq("hy.nt1.pc", 64'(pc), 64'h14);
    redirect(32'h10, "to10d");
    check_eq("hy.c2.predictTaken", 64'(predictTaken), 64'h1);
    check_eq("hy.c2.nextPc", 64'(nextPc), 64'h40);
    resolve(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h40, 32'h40, 1'b1, "hy.nt2");
    check_eq("hy.nt2.pc", 64'(pc), 64'h14);
    redirect(32'h10, "to10e");
    check_eq("hy.c1.predictTaken", 64'(predictTaken), 64'h0);
    check_eq("hy.c1.nextPc", 64'(nextPc), 64'h14);
    check_stats("hy");

    // Masked jr, then the same jr live with a correct prediction
    resolve(1'b0, 1'b1, 1'b1, 1'b1, 32'h20, 32'h100, 32'h24, 1'b0, "jr.masked");
    check_eq("jr.masked.pc", 64'(pc), 64'h10);
    check_stats("jr.masked");
    redirect(32'h20, "to20a");
    check_eq("jr.masked.predictTaken", 64'(predictTaken), 64'h0);
    resolve(1'b0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h100, 32'h100, 1'b0, "jr.live");
    check_eq("jr.live.pc", 64'(pc), 64'h20);
    check_eq("jr.live.predictTaken", 64'(predictTaken), 64'h1);
    check_eq("jr.live.nextPc", 64'(nextPc), 64'h100);
    check_stats("jr.live");
    enable = 1'b1;
    step();
    check_eq("jr.follow.pc", 64'(pc), 64'h100);
    enable = 1'b0;

    // Reset beats an active resolve
    reset = 1'b1;
    resolve(1'b0, 1'b1, 1'b1, 1'b0, 32'h30, 32'h200, 32'h34, 1'b1, "rstres");
    reset = 1'b0;
    check_eq("rstres.pc", 64'(pc), 64'h0);
    check_eq("rstres.predictTaken", 64'(predictTaken), 64'h0);
    check_stats("rstres");
    redirect(32'h30, "to30");
    check_eq("rstres.btb30", 64'(predictTaken), 64'h0);
    redirect(32'h20, "to20b");
    check_eq("rstres.btb20", 64'(predictTaken), 64'h0);
    check_eq("rstres.nextPc20", 64'(nextPc), 64'h24);
    check_stats("post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
